// File: rtl/pipelined_ram.sv
// -----------------------------------------------------------------------------
// pipelined_ram
//
// Single-clock simple dual-port RAM (one write port, one read port) with
// per-byte write enables and a 1- or 2-cycle registered read pipeline.
//
// Parameters
//   DATA_W      word width, multiple of 8 (LANES = DATA_W/8 byte lanes)
//   ADDR_W      address width
//   DEPTH       number of words, 1 <= DEPTH <= 2**ADDR_W
//   RD_LAT      read latency, 1 or 2
//   WRITE_FIRST 1: a same-address read sees the bytes being written
//               0: a same-address read sees the old word
//
// Ports
//   clk        master clock, everything updates on the rising edge
//   rst_n      asynchronous active-low reset (pipeline only, not the array)
//   we         write enable
//   wr_addr    write address (writes at or above DEPTH are dropped)
//   wr_be      per-byte write enable, bit i covers wr_data[8i+7:8i]
//   wr_data    write word
//   re         read enable
//   rd_addr    read address (reads at or above DEPTH return zero)
//   rd_data    read word, holds its value between results
//   rd_valid   one-cycle pulse per completed read
//   init_busy  clear sequencer active
//
// Build option
//   PIPELINED_RAM_CLEAR_EN  when defined, every reset release zeroes the
//   array one word per cycle (init_busy high meanwhile, we/re ignored).
//   When undefined, init_busy is tied low and the array has no reset.
// -----------------------------------------------------------------------------
module pipelined_ram #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int DEPTH       = 32,
    parameter int RD_LAT      = 1,
    parameter int WRITE_FIRST = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  init_busy
);

    localparam int LANES = DATA_W / 8;

    // Extended by one bit so DEPTH == 2**ADDR_W compares correctly.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    // -------------------------------------------------------------------------
    // Clear sequencer
    // -------------------------------------------------------------------------
    logic              clr_busy;
    logic [ADDR_W-1:0] clr_addr;

`ifdef PIPELINED_RAM_CLEAR_EN
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

    logic              clr_busy_q, clr_busy_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    always_comb begin
        clr_busy_d = clr_busy_q;
        clr_addr_d = clr_addr_q;
        if (clr_busy_q) begin
            // The last word is written on the same edge that drops busy.
            if ({1'b0, clr_addr_q} == LAST_ADDR) begin
                clr_busy_d = 1'b0;
            end else begin
                clr_addr_d = clr_addr_q + 1'b1;
            end
        end
    end

    // Busy is held high through reset so the sweep restarts from 0 on every
    // release, including a reset that lands mid-sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_busy_q <= 1'b1;
            clr_addr_q <= '0;
        end else begin
            clr_busy_q <= clr_busy_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign clr_busy = clr_busy_q;
    assign clr_addr = clr_addr_q;
`else
    assign clr_busy = 1'b0;
    assign clr_addr = '0;
`endif

    assign init_busy = clr_busy;

    // -------------------------------------------------------------------------
    // Request qualification
    // -------------------------------------------------------------------------
    logic              wr_hit;
    logic              rd_req;
    logic              rd_in_range;
    logic              same_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [LANES-1:0]  mem_lane_we;
    logic [DATA_W-1:0] rd_old;
    logic [DATA_W-1:0] rd_merge;

    always_comb begin
        wr_hit      = we && !clr_busy && ({1'b0, wr_addr} < DEPTH_LIM);
        rd_req      = re && !clr_busy;
        rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
        same_addr   = wr_hit && (wr_addr == rd_addr);
        // The clear sequencer owns the write port while it runs.
        mem_addr    = clr_busy ? clr_addr : wr_addr;
        mem_wdata   = clr_busy ? '0 : wr_data;
    end

    // -------------------------------------------------------------------------
    // Storage: one byte-wide array per lane so byte enables map onto
    // independent write strobes.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];

            assign mem_lane_we[gi] = clr_busy || (wr_hit && wr_be[gi]);

            always_ff @(posedge clk) begin
                if (mem_lane_we[gi]) begin
                    mem[mem_addr] <= mem_wdata[8*gi +: 8];
                end
            end

            assign rd_old[8*gi +: 8] = mem[rd_addr];

            // Write-first bypass is per lane: only enabled bytes are
            // forwarded, the rest come from the stored word.
            assign rd_merge[8*gi +: 8] =
                ((WRITE_FIRST != 0) && same_addr && wr_be[gi]) ?
                wr_data[8*gi +: 8] : rd_old[8*gi +: 8];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Stage 1: array read captured into the first pipeline register.
    // Data only moves on a read so the output holds between results.
    // -------------------------------------------------------------------------
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q,  s1_data_d;

    always_comb begin
        s1_valid_d = rd_req;
        s1_data_d  = s1_data_q;
        if (rd_req) begin
            s1_data_d = rd_in_range ? rd_merge : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    // -------------------------------------------------------------------------
    // Optional stage 2: plain register copy of stage 1.
    // -------------------------------------------------------------------------
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s2_valid_q, s2_valid_d;
            logic [DATA_W-1:0] s2_data_q,  s2_data_d;

            always_comb begin
                s2_valid_d = s1_valid_q;
                s2_data_d  = s2_data_q;
                if (s1_valid_q) begin
                    s2_data_d = s1_data_q;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_data_q  <= s2_data_d;
                end
            end

            assign rd_valid = s2_valid_q;
            assign rd_data  = s2_data_q;
        end else begin : g_lat1
            assign rd_valid = s1_valid_q;
            assign rd_data  = s1_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_ram.sv
// -----------------------------------------------------------------------------
// tb_pipelined_ram
//
// Two instances share one stimulus stream:
//   dut_a : DATA_W=32, DEPTH=20, RD_LAT=1, WRITE_FIRST=0
//   dut_b : DATA_W=32, DEPTH=20, RD_LAT=2, WRITE_FIRST=1
// A reference model (word array + queues of pending read results tagged with
// the edge after which they are due) predicts both outputs. Inputs are driven
// and outputs sampled on the falling edge. Honours PIPELINED_RAM_CLEAR_EN.
// -----------------------------------------------------------------------------
module tb_pipelined_ram;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int DEP = 20;

`ifdef PIPELINED_RAM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [3:0]    wr_be = '0;
    logic [DW-1:0] wr_data = '0;
    logic          re = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          rd_valid_a, rd_valid_b;
    logic          init_busy_a, init_busy_b;

    always #5 clk = ~clk;

    pipelined_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(1), .WRITE_FIRST(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .re(re), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .init_busy(init_busy_a)
    );

    pipelined_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(2), .WRITE_FIRST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .re(re), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .init_busy(init_busy_b)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic [31:0] mdl_mem [DEP];
    rd_t         pend_a[$];
    rd_t         pend_b[$];
    logic [31:0] last_a;
    logic [31:0] last_b;
    int          edge_n   = 0;
    int          busy_cnt = 0;
    bit          in_reset = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word a read of `addr` returns when sampled together with the given write.
    function automatic logic [31:0] read_ref(input int addr, input bit w, input int wa,
                                             input logic [3:0] be, input logic [31:0] wd,
                                             input bit wf);
        logic [31:0] v;
        if (addr >= DEP) return 32'h0;
        v = mdl_mem[addr];
        if (wf && w && wa < DEP && wa == addr) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) v[8*l +: 8] = wd[8*l +: 8];
            end
        end
        return v;
    endfunction

    // Apply one cycle of stimulus (called at a falling edge), advance the
    // model across the rising edge and check outputs at the next falling edge.
    task automatic step(input bit w, input int wa, input logic [3:0] be,
                        input logic [31:0] wd, input bit r, input int ra);
        rd_t e;
        bit  ev_a;
        bit  ev_b;
        we      = w;
        wr_addr = AW'(wa);
        wr_be   = be;
        wr_data = wd;
        re      = r;
        rd_addr = AW'(ra);
        @(posedge clk);
        edge_n++;
        if (!in_reset) begin
            if (busy_cnt > 0) begin
                busy_cnt--;
            end else begin
                if (r) begin
                    e.due  = edge_n;
                    e.data = read_ref(ra, w, wa, be, wd, 1'b0);
                    pend_a.push_back(e);
                    e.due  = edge_n + 1;
                    e.data = read_ref(ra, w, wa, be, wd, 1'b1);
                    pend_b.push_back(e);
                end
                if (w && wa < DEP) begin
                    for (int l = 0; l < 4; l++) begin
                        if (be[l]) mdl_mem[wa][8*l +: 8] = wd[8*l +: 8];
                    end
                end
            end
        end
        @(negedge clk);
        ev_a = 1'b0;
        ev_b = 1'b0;
        if (pend_a.size() > 0 && pend_a[0].due == edge_n) begin
            e = pend_a.pop_front();
            last_a = e.data;
            ev_a = 1'b1;
        end
        if (pend_b.size() > 0 && pend_b[0].due == edge_n) begin
            e = pend_b.pop_front();
            last_b = e.data;
            ev_b = 1'b1;
        end
        check_eq("a_valid", {31'b0, rd_valid_a}, {31'b0, ev_a});
        check_eq("a_data",  rd_data_a, last_a);
        check_eq("b_valid", {31'b0, rd_valid_b}, {31'b0, ev_b});
        check_eq("b_data",  rd_data_b, last_b);
        check_eq("a_busy",  {31'b0, init_busy_a}, {31'b0, CLR && (in_reset || busy_cnt > 0)});
        check_eq("b_busy",  {31'b0, init_busy_b}, {31'b0, CLR && (in_reset || busy_cnt > 0)});
        $display("txn %0d: we=%0b wa=%0d be=%h wd=%h re=%0b ra=%0d | a v=%0b d=%h | b v=%0b d=%h",
                 edge_n, w, wa, be, wd, r, ra, rd_valid_a, rd_data_a, rd_valid_b, rd_data_b);
    endtask

    task automatic idle();
        step(1'b0, 0, 4'h0, 32'h0, 1'b0, 0);
    endtask

    // Assert reset asynchronously mid-cycle, hold it, then release.
    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        #1;
        in_reset = 1'b1;
        pend_a.delete();
        pend_b.delete();
        last_a = '0;
        last_b = '0;
        check_eq("rst_a_valid", {31'b0, rd_valid_a}, 32'h0);
        check_eq("rst_a_data",  rd_data_a, 32'h0);
        check_eq("rst_b_valid", {31'b0, rd_valid_b}, 32'h0);
        check_eq("rst_b_data",  rd_data_b, 32'h0);
        for (int i = 0; i < hold; i++) idle();
        rst_n    = 1'b1;
        in_reset = 1'b0;
        if (CLR) begin
            busy_cnt = DEP;
            for (int i = 0; i < DEP; i++) mdl_mem[i] = 32'h0;
        end
    endtask

    // While clearing, hammer we/re randomly; the model expects them ignored.
    task automatic ride_clear();
        for (int i = 0; i < DEP + 2 && busy_cnt > 0; i++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, DEP - 1), 4'hF, $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(0, DEP - 1));
        end
    endtask

    initial begin
        int wa;
        int ra;
        last_a = '0;
        last_b = '0;
        @(negedge clk);
        do_reset(3);
        ride_clear();
        // After a clear every word must read back as zero; without the
        // clear the model holds X here and the sweep is skipped.
`ifdef PIPELINED_RAM_CLEAR_EN
        for (int a = 0; a < DEP; a++) step(1'b0, 0, 4'h0, 32'h0, 1'b1, a);
        idle();
`endif
        for (int a = 0; a < DEP; a++) step(1'b1, a, 4'hF, $urandom, 1'b0, 0);
        for (int a = 0; a < DEP; a++) step(1'b0, 0, 4'h0, 32'h0, 1'b1, a);
        idle();

        // Single-byte write then read, followed by an idle hold cycle.
        step(1'b1, 3, 4'h1, 32'h000000A5, 1'b0, 0);
        step(1'b0, 0, 4'h0, 32'h0, 1'b1, 3);
        check_eq("a5_lane0", {24'h0, rd_data_a[7:0]}, 32'h000000A5);
        idle();
        check_eq("a5_hold", {24'h0, rd_data_a[7:0]}, 32'h000000A5);
        idle();

        // Byte-enable merge.
        step(1'b1, 7, 4'hF, 32'h11223344, 1'b0, 0);
        step(1'b1, 7, 4'b0101, 32'hAABBCCDD, 1'b0, 0);
        step(1'b0, 0, 4'h0, 32'h0, 1'b1, 7);
        check_eq("be_merge_a", rd_data_a, 32'h11BB33DD);
        idle();
        check_eq("be_merge_b", rd_data_b, 32'h11BB33DD);

        // Same-edge read/write collision: old word vs write-first merge.
        step(1'b1, 2, 4'hF, 32'h00000000, 1'b0, 0);
        step(1'b1, 2, 4'b0011, 32'hFFFFFFFF, 1'b1, 2);
        check_eq("collide_rf", rd_data_a, 32'h00000000);
        idle();
        check_eq("collide_wf", rd_data_b, 32'h0000FFFF);
        idle();

        // Back-to-back reads including the last word and an out-of-range one.
        step(1'b0, 0, 4'h0, 32'h0, 1'b1, 0);
        step(1'b0, 0, 4'h0, 32'h0, 1'b1, 1);
        step(1'b0, 0, 4'h0, 32'h0, 1'b1, 19);
        step(1'b0, 0, 4'h0, 32'h0, 1'b1, 25);
        check_eq("oob_a", rd_data_a, 32'h0);
        idle();
        check_eq("oob_b_valid", {31'b0, rd_valid_b}, 32'h1);
        check_eq("oob_b", rd_data_b, 32'h0);
        idle();

        // Out-of-range and empty-byte-enable writes must not disturb memory.
        step(1'b1, 20, 4'hF, 32'hDEADBEEF, 1'b0, 0);
        step(1'b1, 4, 4'h0, 32'hDEADBEEF, 1'b0, 0);
        step(1'b0, 0, 4'h0, 32'h0, 1'b1, 4);
        idle();

        // Read in flight when reset hits: no result may emerge.
        step(1'b0, 0, 4'h0, 32'h0, 1'b1, 5);
        do_reset(2);
        ride_clear();
        for (int i = 0; i < 3; i++) idle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            wa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, DEP - 1);
            ra = ($urandom_range(0, 2) == 0) ? wa :
                 (($urandom_range(0, 5) == 0) ? $urandom_range(0, 31) : $urandom_range(0, DEP - 1));
            step(1'($urandom_range(0, 1)), wa, 4'($urandom), $urandom,
                 1'($urandom_range(0, 2) != 0), ra);
        end
        for (int i = 0; i < 3; i++) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
